// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM states, default width
// and the signed-overflow rule applied to the captured operands.
package serial_subtractor_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                      input logic d_msb);
    return (a_msb != b_msb) && (d_msb != a_msb);
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle of the serial subtractor; master drives operands,
// slave (the subtractor) returns status and registered results.
interface serial_subtractor_if
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             borrow_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             overflow;

  modport master (
    output start, a, b, borrow_in,
    input  busy, done, diff, borrow_out, overflow
  );

  modport slave (
    input  start, a, b, borrow_in,
    output busy, done, diff, borrow_out, overflow
  );
endinterface

// File: rtl/subtractor_1bit.sv
// One-bit full subtractor: diff = a - b - borrow_in with outgoing borrow.
module subtractor_1bit (
  input  logic a,
  input  logic b,
  input  logic borrow_in,
  output logic diff,
  output logic borrow_out
);
  assign diff       = a ^ b ^ borrow_in;
  assign borrow_out = (~a & b) | (~(a ^ b) & borrow_in);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: loads operands on start, processes one bit per cycle
// LSB first, then publishes diff/borrow_out/overflow with a one-cycle done.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input logic                clk,
  input logic                rst,
  serial_subtractor_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             brw_q, brw_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_out_q, borrow_out_d;
  logic             overflow_q, overflow_d;

  logic bit_diff;
  logic bit_borrow;

  subtractor_1bit u_bit (
    .a          (a_sr_q[0]),
    .b          (b_sr_q[0]),
    .borrow_in  (brw_q),
    .diff       (bit_diff),
    .borrow_out (bit_borrow)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      a_sr_q       <= '0;
      b_sr_q       <= '0;
      res_q        <= '0;
      brw_q        <= 1'b0;
      cnt_q        <= '0;
      a_msb_q      <= 1'b0;
      b_msb_q      <= 1'b0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_sr_q       <= a_sr_d;
      b_sr_q       <= b_sr_d;
      res_q        <= res_d;
      brw_q        <= brw_d;
      cnt_q        <= cnt_d;
      a_msb_q      <= a_msb_d;
      b_msb_q      <= b_msb_d;
      diff_q       <= diff_d;
      borrow_out_q <= borrow_out_d;
      overflow_q   <= overflow_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    a_sr_d       = a_sr_q;
    b_sr_d       = b_sr_q;
    res_d        = res_q;
    brw_d        = brw_q;
    cnt_d        = cnt_q;
    a_msb_d      = a_msb_q;
    b_msb_d      = b_msb_q;
    diff_d       = diff_q;
    borrow_out_d = borrow_out_q;
    overflow_d   = overflow_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_sr_d  = bus.a;
          b_sr_d  = bus.b;
          brw_d   = bus.borrow_in;
          res_d   = '0;
          cnt_d   = '0;
          a_msb_d = bus.a[WIDTH-1];
          b_msb_d = bus.b[WIDTH-1];
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Counter reaching WIDTH means all bits are in res_q; publish on DONE entry.
        if (cnt_q == CW'(WIDTH)) begin
          diff_d       = res_q;
          borrow_out_d = brw_q;
          overflow_d   = signed_ovf(a_msb_q, b_msb_q, res_q[WIDTH-1]);
          state_d      = DONE;
        end else begin
          a_sr_d = a_sr_q >> 1;
          b_sr_d = b_sr_q >> 1;
          res_d  = {bit_diff, res_q[WIDTH-1:1]};
          brw_d  = bit_borrow;
          cnt_d  = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = (state_q == DONE);
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_out_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and exhaustive checks of serial_subtractor at WIDTH=4.
module tb_serial_subtractor;
  import serial_subtractor_pkg::*;

  localparam int unsigned W = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issues one operation, waits (bounded) for done; returns edges from accept to done.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        output int lat);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.a         = a;
    bus.b         = b;
    bus.borrow_in = bin;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat = 0;
    while (bus.done !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic finish_op();
    @(posedge clk);
    #1;
  endtask

  int lat;
  int ndone;
  logic [W:0]   full;
  logic [W-1:0] ed;
  logic         eo;

  initial begin
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.borrow_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_outs", {bus.diff, bus.borrow_out, bus.overflow}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Idle with start low: operands must not disturb anything.
    bus.a = 4'hF; bus.b = 4'h1; bus.borrow_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_busy", 32'(bus.busy), 32'd0);
    check("idle_outs", {bus.diff, bus.borrow_out, bus.overflow}, 32'd0);

    // 5 - 3 = 2
    run_op(4'd5, 4'd3, 1'b0, lat);
    check("lat_5m3", 32'(lat), 32'd5);
    check("res_5m3", {bus.diff, bus.borrow_out, bus.overflow}, {4'h2, 1'b0, 1'b0});
    check("busy_in_done", 32'(bus.busy), 32'd1);
    finish_op();
    check("done_pulse", {bus.done, bus.busy}, 32'd0);
    check("hold_5m3", 32'(bus.diff), 32'h2);

    // 3 - 5 = E, borrow
    run_op(4'd3, 4'd5, 1'b0, lat);
    check("lat_3m5", 32'(lat), 32'd5);
    check("res_3m5", {bus.diff, bus.borrow_out, bus.overflow}, {4'hE, 1'b1, 1'b0});
    finish_op();

    // 8 - 1 = 7, signed overflow
    run_op(4'h8, 4'd1, 1'b0, lat);
    check("res_8m1", {bus.diff, bus.borrow_out, bus.overflow}, {4'h7, 1'b0, 1'b1});
    finish_op();

    // 0 - 0 - 1 = F, borrow
    run_op(4'd0, 4'd0, 1'b1, lat);
    check("res_0m0b", {bus.diff, bus.borrow_out, bus.overflow}, {4'hF, 1'b1, 1'b0});
    finish_op();

    // start held with 9/9 on every busy cycle of a 5-3 operation
    @(negedge clk);
    bus.start = 1'b1; bus.a = 4'd5; bus.b = 4'd3; bus.borrow_in = 1'b0;
    @(posedge clk);
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) ndone++;
      check($sformatf("ign_cyc%0d", i), {bus.done, bus.diff},
            (i == 5) ? {1'b1, 4'h2} : {1'b0, 4'hF});
      bus.start = 1'b1; bus.a = 4'd9; bus.b = 4'd9;
    end
    @(negedge clk);
    bus.start = 1'b0;
    check("ign_idle", {bus.busy, bus.done}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("ign_ndone", 32'(ndone), 32'd1);
    check("ign_noacc", {bus.busy, bus.diff}, {1'b0, 4'h2});

    // Reset mid-operation, preceded by a result with nonzero flags
    run_op(4'h8, 4'd1, 1'b0, lat);
    finish_op();
    @(negedge clk);
    bus.start = 1'b1; bus.a = 4'd6; bus.b = 4'd1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_busy", {bus.busy, bus.done}, 32'd0);
    check("rst_async_outs", {bus.diff, bus.borrow_out, bus.overflow}, 32'd0);
    ndone = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (bus.done !== 1'b0) ndone++;
    end
    check("rst_no_done", 32'(ndone), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(4'd7, 4'd2, 1'b0, lat);
    check("lat_after_rst", 32'(lat), 32'd5);
    check("res_7m2", {bus.diff, bus.borrow_out, bus.overflow}, {4'h5, 1'b0, 1'b0});
    finish_op();

    // Exhaustive sweep against an arithmetic reference
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          full = {1'b0, 4'(ia)} - {1'b0, 4'(ib)} - 5'(ic);
          ed   = full[W-1:0];
          eo   = (ia[3] != ib[3]) && (ed[3] != ia[3]);
          run_op(4'(ia), 4'(ib), 1'(ic), lat);
          check($sformatf("sweep_%0d_%0d_%0d", ia, ib, ic),
                {lat[7:0], bus.diff, bus.borrow_out, bus.overflow},
                {8'd5, ed, full[W], eo});
          finish_op();
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
